// File: rtl/apb_slave_regs.sv
// APB3 completer with a word-addressed register file, configurable wait states
// and pslverr on out-of-range accesses.
module apb_slave_regs #(
  parameter int DEPTH       = 16,
  parameter int WAIT_STATES = 0
) (
  input  logic        pclk,
  input  logic        prst,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [31:0] paddr,
  input  logic [31:0] pwdata,
  output logic [31:0] prdata,
  output logic        pready,
  output logic        pslverr
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t      state, state_n;
  logic [3:0]  cnt, cnt_n;
  logic [31:0] lat_addr, lat_wdata;
  logic        lat_write;
  logic        pready_n, pslverr_n;
  logic [31:0] prdata_n;
  logic        latch, commit;
  logic [31:0] regs [DEPTH];
  logic [31:0] rd_addr, rd_data;
  logic        rd_ok, lat_ok;

  // In IDLE a zero-wait read must use the live bus address; otherwise the latched one.
  assign rd_addr = (state == IDLE) ? paddr : lat_addr;
  assign rd_ok   = rd_addr < 32'(DEPTH);
  assign rd_data = rd_ok ? regs[rd_addr[AW-1:0]] : '0;
  assign lat_ok  = lat_addr < 32'(DEPTH);

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    pready_n  = pready;
    pslverr_n = pslverr;
    prdata_n  = prdata;
    latch     = 1'b0;
    commit    = 1'b0;
    case (state)
      IDLE: begin
        if (psel && !penable) begin
          latch   = 1'b1;
          cnt_n   = 4'(WAIT_STATES);
          state_n = ACCESS;
          if (WAIT_STATES == 0) begin
            pready_n  = 1'b1;
            pslverr_n = !rd_ok;
            if (!pwrite) prdata_n = rd_data;
          end
        end
      end
      ACCESS: begin
        if (!psel) begin
          state_n   = IDLE;
          pready_n  = 1'b0;
          pslverr_n = 1'b0;
        end else if (pready) begin
          commit    = lat_write && lat_ok;
          state_n   = IDLE;
          pready_n  = 1'b0;
          pslverr_n = 1'b0;
        end else if (cnt > 4'd1) begin
          cnt_n = cnt - 4'd1;
        end else begin
          cnt_n     = 4'd0;
          pready_n  = 1'b1;
          pslverr_n = !lat_ok;
          if (!lat_write) prdata_n = rd_data;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (prst) begin
      state     <= IDLE;
      cnt       <= '0;
      prdata    <= '0;
      pready    <= 1'b0;
      pslverr   <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_write <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      prdata  <= prdata_n;
      pready  <= pready_n;
      pslverr <= pslverr_n;
      if (latch) begin
        lat_addr  <= paddr;
        lat_wdata <= pwdata;
        lat_write <= pwrite;
      end
    end
  end

  // Reset has priority, so a write caught mid-flight by prst is never committed.
  always_ff @(posedge pclk) begin
    if (prst) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (commit) begin
      regs[lat_addr[AW-1:0]] <= lat_wdata;
    end
  end

endmodule

// File: tb/tb_apb_slave_regs.sv
// Directed bench: one zero-wait instance (d=0) and one two-wait instance (d=1)
// driven through per-feature tasks with hand-computed expectations.
module tb_apb_slave_regs;

  logic        pclk = 1'b0;
  logic        prst;
  logic        psel0, penable0, pwrite0, pready0, pslverr0;
  logic [31:0] paddr0, pwdata0, prdata0;
  logic        psel2, penable2, pwrite2, pready2, pslverr2;
  logic [31:0] paddr2, pwdata2, prdata2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 pclk = ~pclk;

  apb_slave_regs #(.DEPTH(16), .WAIT_STATES(0)) dut0 (
    .pclk(pclk), .prst(prst), .psel(psel0), .penable(penable0), .pwrite(pwrite0),
    .paddr(paddr0), .pwdata(pwdata0), .prdata(prdata0), .pready(pready0), .pslverr(pslverr0)
  );

  apb_slave_regs #(.DEPTH(16), .WAIT_STATES(2)) dut2 (
    .pclk(pclk), .prst(prst), .psel(psel2), .penable(penable2), .pwrite(pwrite2),
    .paddr(paddr2), .pwdata(pwdata2), .prdata(prdata2), .pready(pready2), .pslverr(pslverr2)
  );

  task automatic drive(input int d, input logic s, input logic e, input logic w,
                       input logic [31:0] a, input logic [31:0] wd);
    if (d == 0) begin
      psel0 = s; penable0 = e; pwrite0 = w; paddr0 = a; pwdata0 = wd;
    end else begin
      psel2 = s; penable2 = e; pwrite2 = w; paddr2 = a; pwdata2 = wd;
    end
  endtask

  task automatic sample(input int d, output logic [31:0] rd, output logic rdy, output logic err);
    if (d == 0) begin
      rd = prdata0; rdy = pready0; err = pslverr0;
    end else begin
      rd = prdata2; rdy = pready2; err = pslverr2;
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  // Full transfer; n is the access cycle (1-based) in which pready was seen.
  task automatic xfer(input int d, input logic w, input logic [31:0] a, input logic [31:0] wd,
                      output logic [31:0] rd, output logic err, output int n);
    logic rdy;
    drive(d, 1'b1, 1'b0, w, a, wd);
    tick();
    drive(d, 1'b1, 1'b1, w, a, wd);
    n = 1;
    sample(d, rd, rdy, err);
    while (!rdy && n < 40) begin
      tick();
      n++;
      sample(d, rd, rdy, err);
    end
    tick();
    drive(d, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic test_reset();
    prst = 1'b1;
    drive(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (3) tick();
    n_checks++;
    if (pready0 !== 1'b0 || pslverr0 !== 1'b0 || prdata0 !== 32'h0) begin
      n_fail++;
      $display("[TB] FAIL reset_dut0: pready=%b pslverr=%b prdata=%h, want 0/0/0", pready0, pslverr0, prdata0);
    end
    n_checks++;
    if (pready2 !== 1'b0 || pslverr2 !== 1'b0 || prdata2 !== 32'h0) begin
      n_fail++;
      $display("[TB] FAIL reset_dut2: pready=%b pslverr=%b prdata=%h, want 0/0/0", pready2, pslverr2, prdata2);
    end
    prst = 1'b0;
    tick();
  endtask

  task automatic test_write_ws0();
    logic [31:0] rd;
    logic        err;
    int          n;
    for (int i = 0; i <= 10; i++) begin
      xfer(0, 1'b1, 32'(i), 32'(i * 5), rd, err, n);
      n_checks++;
      if (n !== 1 || err !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL write_ws0[%0d]: cycle=%0d err=%b, want 1/0", i, n, err);
      end
    end
  endtask

  task automatic test_readback();
    logic [31:0] rd;
    logic        err;
    int          n;
    for (int i = 0; i <= 15; i++) begin
      xfer(0, 1'b0, 32'(i), 32'h0, rd, err, n);
      n_checks++;
      if (rd !== ((i <= 10) ? 32'(i * 5) : 32'h0) || err !== 1'b0 || n !== 1) begin
        n_fail++;
        $display("[TB] FAIL readback[%0d]: prdata=%h err=%b cycle=%0d, want %h/0/1",
                 i, rd, err, n, (i <= 10) ? 32'(i * 5) : 32'h0);
      end
    end
  endtask

  task automatic test_wait_states();
    logic [31:0] rd;
    logic        err, rdy;
    int          n;
    xfer(1, 1'b0, 32'd3, 32'h0, rd, err, n);
    n_checks++;
    if (rd !== 32'h0 || n !== 3) begin
      n_fail++;
      $display("[TB] FAIL ws_old_value: prdata=%h cycle=%0d, want 0/3", rd, n);
    end
    // Address/data change during ACCESS must be ignored.
    drive(1, 1'b1, 1'b0, 1'b1, 32'd3, 32'h1234);
    tick();
    drive(1, 1'b1, 1'b1, 1'b1, 32'd7, 32'h0BAD);
    for (int c = 1; c <= 3; c++) begin
      sample(1, rd, rdy, err);
      n_checks++;
      if (rdy !== (c == 3) || err !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL ws_pready_T+%0d: pready=%b pslverr=%b, want %b/0", c, rdy, err, c == 3);
      end
      tick();
    end
    drive(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    xfer(1, 1'b0, 32'd3, 32'h0, rd, err, n);
    n_checks++;
    if (rd !== 32'h1234 || err !== 1'b0 || n !== 3) begin
      n_fail++;
      $display("[TB] FAIL ws_readback3: prdata=%h err=%b cycle=%0d, want 00001234/0/3", rd, err, n);
    end
    xfer(1, 1'b0, 32'd7, 32'h0, rd, err, n);
    n_checks++;
    if (rd !== 32'h0 || err !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL ws_ignored_addr7: prdata=%h err=%b, want 0/0", rd, err);
    end
  endtask

  task automatic test_error();
    logic [31:0] rd;
    logic        err;
    int          n;
    xfer(0, 1'b0, 32'd5, 32'h0, rd, err, n);
    xfer(0, 1'b1, 32'd20, 32'hDEAD_BEEF, rd, err, n);
    n_checks++;
    if (err !== 1'b1 || n !== 1 || rd !== 32'd25) begin
      n_fail++;
      $display("[TB] FAIL err_write20: err=%b cycle=%0d prdata=%h, want 1/1/00000019", err, n, rd);
    end
    xfer(0, 1'b0, 32'd20, 32'h0, rd, err, n);
    n_checks++;
    if (rd !== 32'h0 || err !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL err_read20: prdata=%h err=%b, want 0/1", rd, err);
    end
    xfer(0, 1'b0, 32'd16, 32'h0, rd, err, n);
    n_checks++;
    if (rd !== 32'h0 || err !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL err_read16: prdata=%h err=%b, want 0/1", rd, err);
    end
    xfer(0, 1'b0, 32'h1000_0003, 32'h0, rd, err, n);
    n_checks++;
    if (rd !== 32'h0 || err !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL err_read_hi_bits: prdata=%h err=%b, want 0/1", rd, err);
    end
    xfer(0, 1'b0, 32'd4, 32'h0, rd, err, n);
    n_checks++;
    if (rd !== 32'd20 || err !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL err_read4_after: prdata=%h err=%b, want 00000014/0", rd, err);
    end
    xfer(0, 1'b0, 32'd15, 32'h0, rd, err, n);
    n_checks++;
    if (rd !== 32'h0 || err !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL err_read15_valid: prdata=%h err=%b, want 0/0", rd, err);
    end
  endtask

  task automatic test_abort();
    logic [31:0] rd;
    logic        err, rdy;
    int          n;
    xfer(1, 1'b0, 32'd3, 32'h0, rd, err, n);
    drive(1, 1'b1, 1'b0, 1'b1, 32'd4, 32'h55);
    tick();
    drive(1, 1'b0, 1'b1, 1'b1, 32'd4, 32'h55);
    tick();
    drive(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    for (int c = 0; c < 4; c++) begin
      sample(1, rd, rdy, err);
      n_checks++;
      if (rdy !== 1'b0 || err !== 1'b0 || rd !== 32'h1234) begin
        n_fail++;
        $display("[TB] FAIL abort_idle[%0d]: pready=%b pslverr=%b prdata=%h, want 0/0/00001234", c, rdy, err, rd);
      end
      tick();
    end
    drive(1, 1'b1, 1'b1, 1'b0, 32'd4, 32'h0);
    for (int c = 0; c < 4; c++) begin
      tick();
      sample(1, rd, rdy, err);
      n_checks++;
      if (rdy !== 1'b0 || err !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL violation[%0d]: pready=%b pslverr=%b, want 0/0", c, rdy, err);
      end
    end
    drive(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    xfer(1, 1'b0, 32'd4, 32'h0, rd, err, n);
    n_checks++;
    if (rd !== 32'h0 || err !== 1'b0 || n !== 3) begin
      n_fail++;
      $display("[TB] FAIL abort_read4: prdata=%h err=%b cycle=%0d, want 0/0/3", rd, err, n);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd;
    logic        err;
    int          n;
    xfer(0, 1'b0, 32'd10, 32'h0, rd, err, n);
    drive(0, 1'b1, 1'b0, 1'b1, 32'd2, 32'h77);
    tick();
    drive(0, 1'b1, 1'b1, 1'b1, 32'd2, 32'h77);
    prst = 1'b1;
    tick();
    n_checks++;
    if (pready0 !== 1'b0 || prdata0 !== 32'h0 || pslverr0 !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_mid: pready=%b prdata=%h pslverr=%b, want 0/0/0", pready0, prdata0, pslverr0);
    end
    prst = 1'b0;
    drive(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    xfer(0, 1'b0, 32'd2, 32'h0, rd, err, n);
    n_checks++;
    if (rd !== 32'h0 || err !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_mid_read2: prdata=%h err=%b, want 0/0", rd, err);
    end
    xfer(0, 1'b0, 32'd5, 32'h0, rd, err, n);
    n_checks++;
    if (rd !== 32'h0 || err !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_mid_read5: prdata=%h err=%b, want 0/0", rd, err);
    end
  endtask

  initial begin
    test_reset();
    test_write_ws0();
    test_readback();
    test_wait_states();
    test_error();
    test_abort();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
